// File: rtl/i2s_rx.sv
// I2S receiver: 16-bit left/right capture with frame lock and sclk watchdog.
// Optional malformed-word detection is built when I2S_RX_FRAME_ERR_EN is defined.
`timescale 1ns/1ps

module i2s_rx (
  input  logic        clk,
  input  logic        rst,
  input  logic        audio_sclk,
  input  logic        audio_lrck,
  input  logic        audio_adc,
  output logic [15:0] left_audio,
  output logic [15:0] right_audio,
  output logic        sample_valid,
  output logic        locked,
  output logic        frame_err,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  state_t      r_state;
  logic        r_sclkMeta, r_sclkSync, r_sclkPrev;
  logic        r_lrckMeta, r_lrckSync, r_lrckS, r_lrckPrev;
  logic        r_adcMeta, r_adcSync, r_adcS;
  logic        r_rise;
  logic [5:0]  r_bitCnt;
  logic [15:0] r_shift;
  logic [15:0] r_leftHold;
  logic        r_leftOk;
  logic [9:0]  r_wdog;
  logic        w_sclkRise;
  logic        w_lrckChange;

  // Unreset synchronisers; all three inputs share the same stage depth.
  always_ff @(posedge clk) begin
    r_sclkMeta <= audio_sclk;
    r_sclkSync <= r_sclkMeta;
    r_sclkPrev <= r_sclkSync;
    r_lrckMeta <= audio_lrck;
    r_lrckSync <= r_lrckMeta;
    r_adcMeta  <= audio_adc;
    r_adcSync  <= r_adcMeta;
  end

  assign w_sclkRise   = r_sclkSync & ~r_sclkPrev;
  assign w_lrckChange = (r_lrckS != r_lrckPrev);

  // Registered edge detect keeps lrck/adc aligned with the rise they belong to.
  always_ff @(posedge clk) begin
    r_lrckS <= r_lrckSync;
    r_adcS  <= r_adcSync;
    if (rst) r_rise <= 1'b0;
    else     r_rise <= w_sclkRise;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lrckPrev   <= 1'b0;
      r_bitCnt     <= '0;
      r_shift      <= '0;
      r_leftHold   <= '0;
      r_leftOk     <= 1'b0;
      r_wdog       <= '0;
      left_audio   <= '0;
      right_audio  <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (r_rise) begin
        r_wdog     <= '0;
        r_lrckPrev <= r_lrckS;
        case (r_state)
          IDLE: begin
            if (r_lrckPrev && !r_lrckS) begin
              r_state  <= LEFT;
              r_bitCnt <= '0;
              r_shift  <= '0;
              r_leftOk <= 1'b0;
            end
          end
          LEFT, RIGHT: begin
            if (w_lrckChange) begin
              // The change rise is the delay bit: close the word, shift nothing.
              r_bitCnt <= '0;
              r_shift  <= '0;
              if (r_state == LEFT) begin
                r_state    <= RIGHT;
                r_leftHold <= r_shift;
                r_leftOk   <= 1'b1;
              end else begin
                r_state <= LEFT;
                if (r_leftOk) begin
                  left_audio   <= r_leftHold;
                  right_audio  <= r_shift;
                  sample_valid <= 1'b1;
                  locked       <= 1'b1;
                end
              end
            end else begin
              if (r_bitCnt < 6'd16) r_shift[~r_bitCnt[3:0]] <= r_adcS;
              r_bitCnt <= (r_bitCnt == 6'd63) ? 6'd63 : r_bitCnt + 6'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (r_wdog == 10'd1023) begin
        // sclk has stalled: drop lock but keep the last samples on the outputs.
        locked  <= 1'b0;
        r_state <= IDLE;
      end else begin
        r_wdog <= r_wdog + 10'd1;
      end
    end
  end

`ifdef I2S_RX_FRAME_ERR_EN
  logic w_wordBad;
  assign w_wordBad = (r_bitCnt < 6'd16) || (r_bitCnt > 6'd32);

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      frame_err <= 1'b0;
      if (r_rise && (r_state != IDLE) && w_lrckChange && w_wordBad) begin
        frame_err <= 1'b1;
        if (err_count != 8'd255) err_count <= err_count + 8'd1;
      end
    end
  end
`else
  assign frame_err = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: table-driven frames with a scoreboard, plus
// hand sequences for latency, watchdog, mid-word reset and short-word bursts.
`timescale 1ns/1ps

module tb_i2s_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        audio_sclk;
  logic        audio_lrck;
  logic        audio_adc;
  logic [15:0] left_audio;
  logic [15:0] right_audio;
  logic        sample_valid;
  logic        locked;
  logic        frame_err;
  logic [7:0]  err_count;

  i2s_rx dut (
    .clk          (clk),
    .rst          (rst),
    .audio_sclk   (audio_sclk),
    .audio_lrck   (audio_lrck),
    .audio_adc    (audio_adc),
    .left_audio   (left_audio),
    .right_audio  (right_audio),
    .sample_valid (sample_valid),
    .locked       (locked),
    .frame_err    (frame_err),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] leftWord;
    logic [23:0] rightWord;
    int          leftBits;
    int          rightBits;
    int          leftSlot;
    int          rightSlot;
    logic [15:0] expLeft;
    logic [15:0] expRight;
  } vector_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } expect_t;

  vector_t vectors[6];
  vector_t burst;
  expect_t scoreboard[$];

  int   nCompared    = 0;
  int   nMismatch    = 0;
  int   sclkHalf     = 12;
  int   errPulses    = 0;
  int   expErrPulses = 0;
  int   expErrCount  = 0;
  logic prevValid    = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic int isBad(input int n);
    return (n < 16 || n > 32) ? 1 : 0;
  endfunction

  function automatic int sat255(input int n);
    return (n > 255) ? 255 : n;
  endfunction

  // Error bookkeeping only exists when the DUT is built with error detection.
  task automatic noteErrors(input int n);
`ifdef I2S_RX_FRAME_ERR_EN
    expErrPulses += n;
    expErrCount  += n;
`else
    if (n < 0) $display("[TB] negative error count %0d", n);
`endif
  endtask

  // One sclk period: lrck/adc change with sclk low, rise in mid-period.
  task automatic sclkBit(input logic lr, input logic d);
    @(negedge clk);
    audio_sclk = 1'b0;
    audio_lrck = lr;
    audio_adc  = d;
    repeat (sclkHalf) @(negedge clk);
    audio_sclk = 1'b1;
    repeat (sclkHalf - 1) @(negedge clk);
  endtask

  // Delay bit (driven as 1 so a wrongly captured delay bit shows up), then MSB-first data.
  task automatic sendWord(input logic lr, input logic [23:0] word, input int bits, input int slot);
    sclkBit(lr, 1'b1);
    for (int i = 0; i < slot; i++)
      sclkBit(lr, (i < bits) ? word[bits - 1 - i] : 1'b0);
  endtask

  task automatic applyStimulus(input vector_t v);
    expect_t e;
    sendWord(1'b0, v.leftWord, v.leftBits, v.leftSlot);
    sendWord(1'b1, v.rightWord, v.rightBits, v.rightSlot);
    e.l = v.expLeft;
    e.r = v.expRight;
    scoreboard.push_back(e);
    noteErrors(isBad(v.leftSlot) + isBad(v.rightSlot));
  endtask

  task automatic startStream();
    sclkBit(1'b1, 1'b0);
    sclkBit(1'b1, 1'b0);
  endtask

  task automatic closeFrame();
    sclkBit(1'b0, 1'b1);
    repeat (10) @(negedge clk);
  endtask

  // Let the watchdog drop the receiver back to IDLE between sequences.
  task automatic idleOut();
    @(negedge clk);
    audio_sclk = 1'b0;
    repeat (1200) @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_left"},      left_audio,   0);
    checkOutput({tag, "_right"},     right_audio,  0);
    checkOutput({tag, "_valid"},     sample_valid, 0);
    checkOutput({tag, "_locked"},    locked,       0);
    checkOutput({tag, "_frame_err"}, frame_err,    0);
    checkOutput({tag, "_err_count"}, err_count,    0);
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest queued frame.
  always @(negedge clk) begin
    expect_t e;
    if (frame_err) errPulses++;
    if (sample_valid && prevValid) begin
      nCompared++;
      nMismatch++;
      $display("[TB] FAIL valid_width: got 2+ cycle pulse, expected 1 cycle");
    end
    if (sample_valid) begin
      if (scoreboard.size() == 0) begin
        nCompared++;
        nMismatch++;
        $display("[TB] FAIL unexpected_valid: got valid with L=0x%0h R=0x%0h, expected none", left_audio, right_audio);
      end else begin
        e = scoreboard.pop_front();
        checkOutput("left_audio", left_audio, e.l);
        checkOutput("right_audio", right_audio, e.r);
        checkOutput("locked_at_valid", locked, 1);
      end
    end
    prevValid = sample_valid;
  end

  initial begin
    vectors[0] = '{24'h008001, 24'h007FFE, 16, 16, 16, 16, 16'h8001, 16'h7FFE};
    vectors[1] = '{24'h123456, 24'hABCDEF, 24, 24, 32, 32, 16'h1234, 16'hABCD};
    vectors[2] = '{24'h000ABC, 24'h00FFFF, 12, 16, 12, 16, 16'hABC0, 16'hFFFF};
    vectors[3] = '{24'h000000, 24'h00FFFF, 16, 16, 16, 16, 16'h0000, 16'hFFFF};
    vectors[4] = '{24'h0F1E2D, 24'h00A5C3, 20, 16, 20, 16, 16'hF1E2, 16'hA5C3};
    vectors[5] = '{24'h02AAAA, 24'h00005A, 18, 8,  40, 8,  16'hAAAA, 16'h5A00};
    burst      = '{24'h000001, 24'h000000, 1,  1,  1,  1,  16'h8000, 16'h0000};

    rst        = 1'b1;
    audio_sclk = 1'b0;
    audio_lrck = 1'b0;
    audio_adc  = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Table of frames streamed back to back.
    startStream();
    for (int i = 0; i < 6; i++) applyStimulus(vectors[i]);
    closeFrame();
    checkOutput("err_count_table", err_count, sat255(expErrCount));
    idleOut();

    // First valid after IDLE: exact latency, then sclk stalls for the watchdog.
    startStream();
    applyStimulus(vectors[0]);
    @(negedge clk);
    audio_sclk = 1'b0;
    audio_lrck = 1'b0;
    audio_adc  = 1'b1;
    repeat (sclkHalf) @(negedge clk);
    audio_sclk = 1'b1;
    for (int i = 1; i <= 1100; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        checkOutput("latency_early_valid", sample_valid, 0);
        checkOutput("latency_early_locked", locked, 0);
      end
      if (i == 4) begin
        checkOutput("latency_valid", sample_valid, 1);
        checkOutput("latency_locked", locked, 1);
      end
      if (i == sclkHalf) audio_sclk = 1'b0;
      if (i == 1027) checkOutput("wdog_before", locked, 1);
      if (i == 1028) checkOutput("wdog_expire", locked, 0);
      if (i == 1100) begin
        checkOutput("wdog_hold_left", left_audio, 16'h8001);
        checkOutput("wdog_hold_right", right_audio, 16'h7FFE);
        checkOutput("wdog_still_unlocked", locked, 0);
      end
    end

    // Restart after watchdog: lock returns only with the first full frame.
    startStream();
    applyStimulus(vectors[3]);
    checkOutput("relock_pending", locked, 0);
    closeFrame();
    idleOut();

    // Reset at bit 7 of a left word; the partial frame must never surface.
    startStream();
    applyStimulus(vectors[1]);
    sclkBit(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) sclkBit(1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("midword_reset");
    @(negedge clk);
    rst = 1'b0;
    expErrCount = 0;
    for (int i = 7; i < 16; i++) sclkBit(1'b0, 1'b1);
    sendWord(1'b1, 24'h001111, 16, 16);
    applyStimulus(vectors[4]);
    closeFrame();
    checkOutput("err_count_after_reset", err_count, sat255(expErrCount));
    idleOut();

    // 300 one-bit words at the fastest allowed sclk to saturate the error counter.
    sclkHalf = 4;
    startStream();
    for (int i = 0; i < 150; i++) applyStimulus(burst);
    closeFrame();
    checkOutput("err_count_burst", err_count, sat255(expErrCount));
    checkOutput("frame_err_pulses", errPulses, expErrPulses);
    checkOutput("scoreboard_pending", scoreboard.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
